// File: rtl/pairing_host.sv
// pairing_host: host-side controller for the serial pairing wrapper.
// Turns WRITE/READ/RUN/NOP commands plus a parallel word stream into the
// wrapper's bit-serial protocol.
// Ports:
//   clk, reset (async, active-low)
//   cmd_valid/cmd_ready, cmd_op, cmd_addr : command channel
//   wr_data/wr_valid/wr_ready             : operand words, LSB-first
//   rd_data/rd_last/rd_valid/rd_ready     : result words, LSB-first
//   busy                                  : high whenever not IDLE
//   sel, addr, w, update, ready, i        : wrapper controls
//   core_reset                            : arithmetic-core reset pulse
//   o, done                               : wrapper serial out, run complete
module pairing_host #(
  parameter int unsigned W  = 1188,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [5:0]    cmd_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          busy,
  output logic          sel,
  output logic          w,
  output logic          update,
  output logic          ready,
  output logic          i,
  output logic [5:0]    addr,
  output logic          core_reset,
  input  logic          o,
  input  logic          done
);

  localparam int unsigned NW  = (W + DW - 1) / DW;
  localparam int unsigned LW  = W - (NW - 1) * DW;
  localparam int unsigned BW  = $clog2(W + 1);
  localparam int unsigned WCW = $clog2(NW + 1);
  localparam int unsigned BCW = $clog2(DW + 1);
  localparam int unsigned IW  = $clog2(DW);

  localparam logic [BW-1:0]  BIT_LAST  = BW'(W - 1);
  localparam logic [BW-1:0]  BIT_END   = BW'(W);
  localparam logic [WCW-1:0] WORD_LAST = WCW'(NW - 1);
  localparam logic [WCW-1:0] WORD_END  = WCW'(NW);
  localparam logic [BCW-1:0] LEN_FULL  = BCW'(DW);
  localparam logic [BCW-1:0] LEN_LAST  = BCW'(LW);

  typedef enum logic [3:0] {
    IDLE, W_CLR, W_SHIFT, W_COMMIT, R_SEL, R_LOAD, R_SHIFT, RUN_RST, RUN_WAIT
  } state_e;

  state_e         state_q, state_d;
  logic [5:0]     addr_q, addr_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [DW-1:0]  buf_q, buf_d;
  logic [BCW-1:0] buf_cnt_q, buf_cnt_d;
  logic [DW-1:0]  asm_q, asm_d;
  logic [BCW-1:0] asm_cnt_q, asm_cnt_d;
  logic [DW-1:0]  rd_data_q, rd_data_d;
  logic           rd_valid_q, rd_valid_d;
  logic           rd_last_q, rd_last_d;

  logic [BCW-1:0] word_len;
  logic           rd_free;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    buf_d      = buf_q;
    buf_cnt_d  = buf_cnt_q;
    asm_d      = asm_q;
    asm_cnt_d  = asm_cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    sel        = 1'b0;
    w          = 1'b0;
    update     = 1'b0;
    ready      = 1'b0;
    i          = 1'b0;
    core_reset = 1'b0;
    wr_ready   = 1'b0;

    // Length of the word currently being taken (write) or assembled (read).
    word_len = (word_cnt_q == WORD_LAST) ? LEN_LAST : LEN_FULL;
    rd_free  = !rd_valid_q || rd_ready;

    if (rd_valid_q && rd_ready) begin
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d     = cmd_addr;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          buf_d      = '0;
          buf_cnt_d  = '0;
          asm_d      = '0;
          asm_cnt_d  = '0;
          case (cmd_op)
            2'd0:    state_d = W_CLR;
            2'd1:    state_d = R_SEL;
            2'd2:    state_d = RUN_RST;
            default: state_d = IDLE;
          endcase
        end
      end
      W_CLR: begin
        update  = 1'b1;
        state_d = W_SHIFT;
      end
      W_SHIFT: begin
        if (buf_cnt_q != '0) begin
          ready     = 1'b1;
          i         = buf_q[0];
          buf_d     = buf_q >> 1;
          buf_cnt_d = buf_cnt_q - BCW'(1);
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BIT_LAST) state_d = W_COMMIT;
        end
      end
      W_COMMIT: begin
        sel     = 1'b1;
        w       = 1'b1;
        state_d = IDLE;
      end
      R_SEL: begin
        sel     = 1'b1;
        state_d = R_LOAD;
      end
      R_LOAD: begin
        update  = 1'b1;
        state_d = R_SHIFT;
      end
      R_SHIFT: begin
        if (bit_cnt_q != BIT_END) begin
          // The bit that completes a word goes straight to the output
          // register, so a busy output register stalls the serial stream.
          if (asm_cnt_q + BCW'(1) == word_len) begin
            if (rd_free) begin
              ready                        = 1'b1;
              rd_data_d                    = asm_q;
              rd_data_d[asm_cnt_q[IW-1:0]] = o;
              rd_valid_d                   = 1'b1;
              rd_last_d                    = (word_cnt_q == WORD_LAST);
              asm_d                        = '0;
              asm_cnt_d                    = '0;
              word_cnt_d                   = word_cnt_q + WCW'(1);
              bit_cnt_d                    = bit_cnt_q + BW'(1);
            end
          end else begin
            ready                    = 1'b1;
            asm_d[asm_cnt_q[IW-1:0]] = o;
            asm_cnt_d                = asm_cnt_q + BCW'(1);
            bit_cnt_d                = bit_cnt_q + BW'(1);
          end
        end else if (rd_valid_q && rd_ready && rd_last_q) begin
          state_d = IDLE;
        end
      end
      RUN_RST: begin
        core_reset = 1'b1;
        state_d    = RUN_WAIT;
      end
      RUN_WAIT: begin
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new word may land in the buffer as its last bit leaves; the load
    // overrides the shift update above.
    if ((state_q == W_CLR || state_q == W_SHIFT) &&
        buf_cnt_q <= BCW'(1) && word_cnt_q != WORD_END) begin
      wr_ready = 1'b1;
      if (wr_valid) begin
        buf_d      = wr_data;
        buf_cnt_d  = word_len;
        word_cnt_d = word_cnt_q + WCW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      bit_cnt_q  <= '0;
      word_cnt_q <= '0;
      buf_q      <= '0;
      buf_cnt_q  <= '0;
      asm_q      <= '0;
      asm_cnt_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bit_cnt_q  <= bit_cnt_d;
      word_cnt_q <= word_cnt_d;
      buf_q      <= buf_d;
      buf_cnt_q  <= buf_cnt_d;
      asm_q      <= asm_d;
      asm_cnt_q  <= asm_cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign addr      = addr_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;

endmodule

// File: tb/tb_pairing_host.sv
// Self-checking bench for pairing_host with a behavioural wrapper model.
module tb_pairing_host;
  localparam int unsigned W  = 1188;
  localparam int unsigned DW = 32;
  localparam int unsigned NW = 38;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [5:0]    cmd_addr;
  logic [DW-1:0] wr_data;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] rd_data;
  logic          rd_last, rd_valid, rd_ready;
  logic          busy, sel, w, update, ready, i;
  logic [5:0]    addr;
  logic          core_reset;
  logic          o, done;

  int n_cmp = 0;
  int n_err = 0;

  // Wrapper storage element being read and its shift-out position.
  logic [W-1:0] elem;
  int           rp = 0;

  pairing_host #(.W(W), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .busy(busy), .sel(sel), .w(w), .update(update), .ready(ready), .i(i),
    .addr(addr), .core_reset(core_reset), .o(o), .done(done)
  );

  always #5 clk = ~clk;

  assign o = (rp < int'(W)) ? elem[rp] : 1'b0;

  always @(posedge clk) begin
    if (update) rp <= 0;
    else if (ready) rp <= rp + 1;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic issue_cmd(input logic [1:0] op, input logic [5:0] a);
    cmd_op    = op;
    cmd_addr  = a;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    logic [9:0] v;
    v = {busy, wr_ready, rd_valid, rd_last, sel, w, update, ready, i, core_reset};
    n_cmp++;
    if (v !== 10'b0) begin n_err++; $display("FAIL %s_ctrl: got %b want 0000000000", tag, v); end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL %s_cmd_ready: got %b want 1", tag, cmd_ready); end
    n_cmp++;
    if (rd_data !== '0 || addr !== 6'd0) begin
      n_err++; $display("FAIL %s_data_addr: got rd_data=%h addr=%0d want 0/0", tag, rd_data, addr);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_release: cmd_ready=%b want 1", cmd_ready); end
  endtask

  task automatic test_reset_mid;
    int w_seen;
    wr_valid = 1'b1;
    wr_data  = $urandom;
    issue_cmd(2'd0, 6'd9);
    repeat (60) begin wr_data = $urandom; @(negedge clk); end
    #2 reset = 1'b0;
    wr_valid = 1'b0;
    #1 check_reset_outputs("reset_mid");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_mid_release: cmd_ready=%b want 1", cmd_ready); end
    w_seen = 0;
    repeat (20) begin
      if (w || busy) w_seen++;
      @(negedge clk);
    end
    n_cmp++;
    if (w_seen != 0) begin n_err++; $display("FAIL reset_mid_no_commit: w/busy cycles=%0d want 0", w_seen); end
  endtask

  task automatic test_write(input logic [5:0] a, input bit throttle, input bit pattern);
    logic [DW-1:0] wq[NW];
    logic          got[$];
    int rel, widx, hold, upd_cnt, upd_rel, first, last, w_cnt, w_rel, done_rel, bad, bad_idx, gaps, exp_gaps;
    logic [5:0] w_addr;
    bit fin;
    for (int k = 0; k < int'(NW); k++) wq[k] = pattern ? 32'hA5A5A5A5 : $urandom;
    upd_cnt = 0; upd_rel = -1; first = -1; last = -1; w_cnt = 0; w_rel = -1;
    done_rel = -1; widx = 0; hold = 0; fin = 0; w_addr = '0;
    wr_data  = wq[0];
    wr_valid = 1'b1;
    issue_cmd(2'd0, a);
    rel = 1;
    while (!fin && rel < 4000) begin
      if (update) begin upd_cnt++; if (upd_rel < 0) upd_rel = rel; end
      if (ready) begin got.push_back(i); if (first < 0) first = rel; last = rel; end
      if (w) begin w_cnt++; w_rel = rel; w_addr = addr; end
      if (cmd_ready) begin
        fin = 1; done_rel = rel;
      end else if (widx < int'(NW)) begin
        wr_valid = (!throttle || widx == 0 || hold >= 3);
        wr_data  = wq[widx];
        if (!wr_valid && wr_ready) hold++;
        if (wr_valid && wr_ready) begin widx++; hold = 0; end
      end else begin
        wr_valid = 1'b0;
      end
      @(negedge clk);
      rel++;
    end
    wr_valid = 1'b0;
    exp_gaps = throttle ? 3 * (int'(NW) - 1) : 0;
    n_cmp++;
    if (!fin) begin n_err++; $display("FAIL wr_timeout: cmd_ready never returned (rel=%0d)", rel); end
    n_cmp++;
    if (upd_rel != 1 || upd_cnt != 1) begin
      n_err++; $display("FAIL wr_update: first at rel %0d count %0d want rel 1 count 1", upd_rel, upd_cnt);
    end
    n_cmp++;
    if (got.size() != W) begin n_err++; $display("FAIL wr_ready_count: got %0d want %0d", got.size(), W); end
    bad = 0; bad_idx = -1;
    for (int b = 0; b < got.size() && b < int'(W); b++)
      if (got[b] !== wq[b / DW][b % DW]) begin bad++; if (bad_idx < 0) bad_idx = b; end
    n_cmp++;
    if (bad != 0) begin n_err++; $display("FAIL wr_bits: %0d wrong bits, first at %0d want 0 wrong", bad, bad_idx); end
    n_cmp++;
    if (first != 2) begin n_err++; $display("FAIL wr_first_ready: rel %0d want 2", first); end
    gaps = last - first + 1 - got.size();
    n_cmp++;
    if (gaps != exp_gaps) begin n_err++; $display("FAIL wr_gaps: got %0d want %0d", gaps, exp_gaps); end
    n_cmp++;
    if (w_cnt != 1 || w_rel != 2 + int'(W) + exp_gaps || w_addr !== a) begin
      n_err++;
      $display("FAIL wr_commit: w count %0d at rel %0d addr %0d want 1 at rel %0d addr %0d",
               w_cnt, w_rel, w_addr, 2 + int'(W) + exp_gaps, a);
    end
    n_cmp++;
    if (done_rel != 3 + int'(W) + exp_gaps) begin
      n_err++; $display("FAIL wr_idle: cmd_ready at rel %0d want %0d", done_rel, 3 + int'(W) + exp_gaps);
    end
  endtask

  task automatic read_body(input int mode, input logic [5:0] a);
    int rel, k, sel_rel, upd_rel, first, rdy_cnt, done_rel, acc_rel, stab_err;
    bit fin, pend;
    logic [DW-1:0] pdata, ew;
    logic plast;
    logic [5:0] a_seen;
    rel = 1; k = 0; sel_rel = -1; upd_rel = -1; first = -1; rdy_cnt = 0;
    done_rel = -1; acc_rel = -1; stab_err = 0; fin = 0; pend = 0;
    pdata = '0; plast = 1'b0; a_seen = addr;
    while (!fin && rel < 8000) begin
      if (pend && (rd_valid !== 1'b1 || rd_data !== pdata || rd_last !== plast)) stab_err++;
      if (sel && !w && sel_rel < 0) sel_rel = rel;
      if (update && upd_rel < 0) upd_rel = rel;
      if (ready) begin rdy_cnt++; if (first < 0) first = rel; end
      if (cmd_ready) begin
        fin = 1; done_rel = rel;
      end else begin
        rd_ready = (mode == 0) ? ((rel % 2) == 1) : ($urandom_range(0, 1) == 1);
        if (rd_valid && rd_ready) begin
          for (int j = 0; j < int'(DW); j++) begin
            int idx;
            idx = k * int'(DW) + j;
            ew[j] = (idx < int'(W)) ? elem[idx] : 1'b0;
          end
          n_cmp++;
          if (rd_data !== ew || rd_last !== (k == int'(NW) - 1)) begin
            n_err++;
            $display("FAIL rd_word%0d: got %h last=%b want %h last=%b", k, rd_data, rd_last, ew, k == int'(NW) - 1);
          end
          k++; acc_rel = rel; pend = 0;
        end else begin
          pend = rd_valid; pdata = rd_data; plast = rd_last;
        end
      end
      @(negedge clk);
      rel++;
    end
    rd_ready = 1'b0;
    n_cmp++;
    if (!fin) begin n_err++; $display("FAIL rd_timeout: cmd_ready never returned (rel=%0d)", rel); end
    n_cmp++;
    if (sel_rel != 1 || upd_rel != 2 || first != 3) begin
      n_err++; $display("FAIL rd_start: sel/update/ready at %0d/%0d/%0d want 1/2/3", sel_rel, upd_rel, first);
    end
    n_cmp++;
    if (rdy_cnt != int'(W) || k != int'(NW)) begin
      n_err++; $display("FAIL rd_counts: bits %0d words %0d want %0d/%0d", rdy_cnt, k, W, NW);
    end
    n_cmp++;
    if (stab_err != 0) begin n_err++; $display("FAIL rd_hold: %0d unstable cycles want 0", stab_err); end
    n_cmp++;
    if (done_rel != acc_rel + 1 || a_seen !== a) begin
      n_err++; $display("FAIL rd_idle: idle at %0d (want %0d) addr %0d (want %0d)", done_rel, acc_rel + 1, a_seen, a);
    end
  endtask

  task automatic test_read(input int mode, input bit pattern, input logic [5:0] a);
    logic [63:0] pat;
    pat = 64'h0123456789ABCDEF;
    for (int b = 0; b < int'(W); b++) elem[b] = pattern ? pat[b % 64] : 1'($urandom);
    issue_cmd(2'd1, a);
    read_body(mode, a);
  endtask

  task automatic test_run;
    int rel, cr_cnt, cr_rel, busy_cnt;
    bit fin;
    rel = 1; cr_cnt = 0; cr_rel = -1; busy_cnt = 0; fin = 0;
    issue_cmd(2'd2, 6'd17);
    while (!fin && rel < 500) begin
      if (core_reset) begin cr_cnt++; if (cr_rel < 0) cr_rel = rel; end
      if (busy) busy_cnt++;
      if (cmd_ready) fin = 1;
      // done pulses during the core reset (must be ignored), then rises
      // 100 cycles after the core reset pulse ends.
      else done = core_reset || (cr_rel > 0 && rel >= cr_rel + 101);
      @(negedge clk);
      rel++;
    end
    done = 1'b0;
    n_cmp++;
    if (!fin) begin n_err++; $display("FAIL run_timeout: cmd_ready never returned"); end
    n_cmp++;
    if (cr_cnt != 1 || cr_rel != 1) begin
      n_err++; $display("FAIL run_core_reset: count %0d at rel %0d want 1 at rel 1", cr_cnt, cr_rel);
    end
    n_cmp++;
    if (busy_cnt != 102) begin n_err++; $display("FAIL run_busy: %0d cycles want 102", busy_cnt); end
  endtask

  task automatic test_nop_read;
    logic [5:0] a;
    a = 6'($urandom_range(0, 63));
    for (int b = 0; b < int'(W); b++) elem[b] = 1'($urandom);
    cmd_op = 2'd3; cmd_addr = 6'd0; cmd_valid = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL nop_idle: cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
    end
    cmd_op = 2'd1; cmd_addr = a;
    @(negedge clk);
    cmd_valid = 1'b0;
    n_cmp++;
    if (sel !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL nop_read_sel: sel=%b busy=%b want 1/1", sel, busy);
    end
    read_body(1, a);
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_op = 2'd3; cmd_addr = '0;
    wr_data = '0; wr_valid = 1'b0; rd_ready = 1'b0; done = 1'b0;
    elem = '0;
    test_reset;
    test_write(6'd5, 1'b0, 1'b1);
    test_write(6'($urandom_range(0, 63)), 1'b1, 1'b0);
    test_read(0, 1'b1, 6'd12);
    test_read(1, 1'b0, 6'($urandom_range(0, 63)));
    test_run;
    test_nop_read;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pairing_host.md
# pairing_host

Host-side controller for the serial pairing wrapper. It converts a parallel command/word-stream interface into the wrapper's bit-serial protocol: `sel`/`addr`/`w`/`update`/`ready`/`i` out, `o`/`done` in. It writes operands into the core's storage, reads results back LSB-first, and launches and awaits a pairing run. It sits between the system bus adapter and the pairing wrapper.

## Interface

Parameters:

- `W`, 1188: element width in bits, equal to the wrapper shift-register length.
- `DW`, 32: parallel word width. Words per element `NW = ceil(W/DW)`; 38 with defaults.

Ports:

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake.
- `cmd_op`  in  2  command: 0 = WRITE, 1 = READ, 2 = RUN, 3 = NOP.
- `cmd_addr`  in  6  core storage address.
- `wr_data`  in  DW  operand word, LSB-first element order.
- `wr_valid` / `wr_ready`  in/out  1  write-word handshake.
- `rd_data`  out  DW  result word.
- `rd_last`  out  1  marks the final word of an element.
- `rd_valid` / `rd_ready`  out/in  1  read-word handshake.
- `busy`  out  1  high whenever the block is not in IDLE.
- `sel`, `w`, `update`, `ready`, `i`  out  1 each  wrapper controls.
- `addr`  out  6  wrapper address.
- `core_reset`  out  1  active-high arithmetic-core reset pulse.
- `o`, `done`  in  1 each  wrapper serial output and run-complete flag.

## Operation

- States: IDLE, W_CLR, W_SHIFT, W_COMMIT, R_SEL, R_LOAD, R_SHIFT, RUN_RST, RUN_WAIT.
- Command acceptance: `cmd_ready = (state == IDLE)`. A command is accepted on `cmd_valid & cmd_ready`. `cmd_addr` is latched at acceptance and driven on `addr` for the whole command.
- **WRITE**
  - W_CLR drives `update` = 1, which clears the wrapper input register.
  - W_SHIFT sends element bits 0..W-1. In each cycle where a bit is available: `ready` = 1 and `i` = current bit.
  - Words are held in a DW-bit shift buffer. `wr_ready` is high in W_CLR/W_SHIFT when the buffer is empty or its last bit is leaving this cycle, and not all NW words have been taken.
  - The final word contributes only its low `W-(NW-1)*DW` bits (4 with defaults); its upper bits are ignored.
  - After bit W-1: W_COMMIT drives `sel` = 1 and `w` = 1 for one cycle, then returns to IDLE.
- **READ**
  - R_SEL drives `sel` = 1, `w` = 0 for one cycle.
  - R_LOAD drives `update` = 1 for one cycle.
  - R_SHIFT samples `o` in each cycle with `ready` = 1, assembling bits LSB-first into an assembly register.
  - A full word (or the final partial word, zero-padded) moves to the output register when that register is empty or being accepted. Otherwise `ready` stays 0 (stall).
  - `rd_last` is 1 with word NW-1. IDLE is entered on acceptance of the last word.
- **RUN**
  - RUN_RST drives `core_reset` = 1 for one cycle.
  - RUN_WAIT drives `sel` = 0 and waits for `done` = 1. `done` is sampled only from the first RUN_WAIT cycle onward. Then IDLE.
- **NOP**: accepted, no wrapper activity, stays in IDLE.
- Counters: bit counter of width `clog2(W+1)` and word counter of width `clog2(NW+1)`. No wrap: both are cleared at command acceptance.
- Default drive: wrapper controls are 0 in every state not listed above.

## Timing

- Reset (asynchronous, `reset` = 0): state IDLE; all counters and buffers cleared. `cmd_ready` = 1. `busy`, `wr_ready`, `rd_valid`, `rd_last`, `rd_data`, `sel`, `w`, `update`, `ready`, `i`, `addr`, `core_reset` are all 0.
- Reset mid-command aborts immediately. No `w` pulse is issued for a partial write.
- WRITE accepted at cycle T, with `wr_valid` held high:
  - T+1: W_CLR; word 0 is accepted.
  - T+2 .. T+1+W: `ready` = 1 continuously.
  - T+2+W: W_COMMIT.
  - T+3+W: `cmd_ready` = 1.
- `wr_valid` gaps insert `ready` = 0 cycles. No bits are lost or duplicated.
- READ accepted at T, with `rd_ready` high: R_SEL at T+1, R_LOAD at T+2, first `ready` at T+3. Word k is valid on the cycle after its last bit is sampled.
- `rd_valid`/`rd_data`/`rd_last` hold stable until accepted.
- RUN: `core_reset` at T+1. IDLE is entered the cycle after `done` is sampled high.

## Test plan

- **Reset:** assert `reset` = 0 mid-stream → all outputs match the reset values above; `cmd_ready` = 1 on the next edge after release.
- **WRITE back-to-back:** WRITE to addr 5 with 38 words of 0xA5A5A5A5 and continuous `wr_valid` → `update` at T+1, exactly 1188 `ready` cycles, `i` sequence 1,0,1,0,0,1,0,1…, `w` = 1 with `addr` = 5 at T+1190. The bench model of the wrapper register matches the pattern.
- **WRITE throttled:** `wr_valid` low for 3 cycles between every word → `ready` gaps of 3 cycles, identical serial bit sequence, no extra `w` pulses.
- **READ with backpressure:** model drives `o` from 0x0123456789… pattern, `rd_ready` toggling 1/0 → 38 words match the pattern, word 37 has 4 valid bits with upper 28 = 0, `rd_last` only on word 37, no bit lost.
- **RUN:** model raises `done` 100 cycles after `core_reset` → `busy` high for exactly 102 cycles; `done` asserted during RUN_RST is ignored.
- **NOP then READ** issued back-to-back → NOP takes one cycle; R_SEL begins the cycle after READ acceptance.
